// File: rtl/dispatch_credit_sched_pkg.sv
// Shared definitions for the dispatch credit scheduler: unit classes, RS ordering and the
// class-to-RS mapping.
package dispatch_credit_sched_pkg;

  typedef enum logic [2:0] {
    ClsAlu  = 3'd0,
    ClsBru  = 3'd1,
    ClsCsru = 3'd2,
    ClsDiv  = 3'd3,
    ClsMul  = 3'd4,
    ClsLsu  = 3'd5,
    ClsRsvd = 3'd6,
    ClsNop  = 3'd7
  } way_class_e;

  localparam int unsigned NumRs          = 7;
  localparam int unsigned NumWays        = 4;
  localparam int unsigned RsDepthDefault = 4;

  localparam logic [2:0] RsAlu1 = 3'd0;
  localparam logic [2:0] RsAlu2 = 3'd1;
  localparam logic [2:0] RsBru  = 3'd2;
  localparam logic [2:0] RsCsru = 3'd3;
  localparam logic [2:0] RsDiv  = 3'd4;
  localparam logic [2:0] RsMul  = 3'd5;
  localparam logic [2:0] RsLsu  = 3'd6;

  // ALU ways are steered separately; the ALU1 default here is never used for them.
  function automatic logic [2:0] class_to_rs(way_class_e cls);
    logic [2:0] rs;
    case (cls)
      ClsBru:  rs = RsBru;
      ClsCsru: rs = RsCsru;
      ClsDiv:  rs = RsDiv;
      ClsMul:  rs = RsMul;
      ClsLsu:  rs = RsLsu;
      default: rs = RsAlu1;
    endcase
    return rs;
  endfunction

endpackage

// File: rtl/dispatch_grant_chain.sv
// Combinational in-order grant chain over the four decoded ways, with ALU1/ALU2 steering.
// Reports the credits left after this cycle's grants and whether a granted ALU way tie-broke.
module dispatch_grant_chain
  import dispatch_credit_sched_pkg::*;
#(
  parameter int unsigned CW   = 3,
  parameter int unsigned ROBW = 7
) (
  input  logic [NumWays-1:0]          way_valid_i,
  input  logic [3*NumWays-1:0]        way_class_i,
  input  logic [NumWays-1:0]          way_write_i,
  input  logic [ROBW-1:0]             rob_free_i,
  input  logic [ROBW-1:0]             free_reg_i,
  input  logic [NumRs-1:0][CW-1:0]    credit_i,
  input  logic                        alu_ptr_i,
  output logic [NumWays-1:0]          grant_o,
  output logic [NumWays-1:0]          alu_sel_o,
  output logic [NumRs-1:0][CW-1:0]    credit_left_o,
  output logic                        tie_used_o
);

  logic [NumRs-1:0][CW-1:0] rem;
  logic [ROBW-1:0]          wr_cnt;
  logic [ROBW-1:0]          wr_next;
  logic                     blocked;
  logic                     way_ok;
  logic                     pool;
  logic                     tie;
  logic [2:0]               rs_idx;
  way_class_e               cls;

  always_comb begin
    rem        = credit_i;
    grant_o    = '0;
    alu_sel_o  = '0;
    tie_used_o = 1'b0;
    wr_cnt     = '0;
    wr_next    = '0;
    blocked    = 1'b0;
    way_ok     = 1'b0;
    pool       = 1'b0;
    tie        = 1'b0;
    rs_idx     = '0;
    cls        = ClsNop;
    for (int i = 0; i < NumWays; i++) begin
      cls     = way_class_e'(way_class_i[3*i +: 3]);
      wr_next = wr_cnt + ROBW'(way_write_i[i]);
      way_ok  = !blocked && way_valid_i[i] && (ROBW'(i + 1) <= rob_free_i) &&
                (wr_next <= free_reg_i);
      pool    = 1'b0;
      tie     = 1'b0;
      rs_idx  = class_to_rs(cls);
      case (cls)
        ClsAlu: begin
          if (rem[RsAlu1] > rem[RsAlu2]) begin
            pool = 1'b0;
          end else if (rem[RsAlu1] < rem[RsAlu2]) begin
            pool = 1'b1;
          end else begin
            pool = alu_ptr_i;
            tie  = 1'b1;
          end
          rs_idx = pool ? RsAlu2 : RsAlu1;
          way_ok = way_ok && (rem[rs_idx] != '0);
        end
        ClsNop:  ;
        ClsRsvd: way_ok = 1'b0;
        default: way_ok = way_ok && (rem[rs_idx] != '0);
      endcase
      if (way_ok) begin
        grant_o[i] = 1'b1;
        wr_cnt     = wr_next;
        if (cls != ClsNop) rem[rs_idx] = rem[rs_idx] - CW'(1);
        if (cls == ClsAlu) begin
          alu_sel_o[i] = pool;
          tie_used_o   = tie_used_o | tie;
        end
      end else begin
        blocked = 1'b1;
      end
    end
    credit_left_o = rem;
  end

endmodule

// File: rtl/dispatch_credit_sched.sv
// Dispatch credit scheduler: per-RS credit counters, ALU tie-break pointer and sticky overflow
// flag around the combinational grant chain.
module dispatch_credit_sched
  import dispatch_credit_sched_pkg::*;
#(
  parameter int unsigned RS_DEPTH = RsDepthDefault,
  parameter int unsigned CW       = 3,
  parameter int unsigned ROBW     = 7
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 DispatchFlash,
  input  logic [3:0]           WayValid,
  input  logic [11:0]          WayClass,
  input  logic [3:0]           WayWrite,
  input  logic [ROBW-1:0]      RobFreeNumb,
  input  logic [ROBW-1:0]      FreeRegNumb,
  input  logic [13:0]          RsRelease,
  output logic [3:0]           WayGrant,
  output logic [3:0]           WayAluSel,
  output logic [2:0]           GrantCount,
  output logic                 DispatchStop,
  output logic                 CreditErr
);

  logic [NumRs-1:0][CW-1:0] credit_q, credit_d, credit_left;
  logic                     alu_ptr_q, alu_ptr_d;
  logic                     credit_err_q, credit_err_d;
  logic [3:0]               grant, alu_sel;
  logic                     tie_used;
  logic                     hold;
  logic                     ovf;
  logic [CW:0]              sum;

  dispatch_grant_chain #(
    .CW   (CW),
    .ROBW (ROBW)
  ) u_grant_chain (
    .way_valid_i   (WayValid),
    .way_class_i   (WayClass),
    .way_write_i   (WayWrite),
    .rob_free_i    (RobFreeNumb),
    .free_reg_i    (FreeRegNumb),
    .credit_i      (credit_q),
    .alu_ptr_i     (alu_ptr_q),
    .grant_o       (grant),
    .alu_sel_o     (alu_sel),
    .credit_left_o (credit_left),
    .tie_used_o    (tie_used)
  );

  assign hold = Rest | DispatchFlash;

  always_comb begin
    WayGrant     = hold ? '0 : grant;
    WayAluSel    = hold ? '0 : alu_sel;
    DispatchStop = hold ? 1'b0 : |(WayValid & ~grant);
    GrantCount   = '0;
    for (int i = 0; i < 4; i++) GrantCount = GrantCount + 3'(WayGrant[i]);
  end

  // Release is added on top of the post-grant credit; overflow clamps and latches the error.
  always_comb begin
    credit_d     = credit_q;
    ovf          = 1'b0;
    sum          = '0;
    for (int r = 0; r < NumRs; r++) begin
      sum = {1'b0, credit_left[r]} + (CW+1)'(RsRelease[2*r +: 2]);
      if (sum > (CW+1)'(RS_DEPTH)) begin
        credit_d[r] = CW'(RS_DEPTH);
        ovf         = 1'b1;
      end else begin
        credit_d[r] = sum[CW-1:0];
      end
    end
    credit_err_d = credit_err_q | ovf;
    alu_ptr_d    = alu_ptr_q ^ tie_used;
    if (DispatchFlash) begin
      credit_d     = {NumRs{CW'(RS_DEPTH)}};
      credit_err_d = credit_err_q;
      alu_ptr_d    = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rest) begin
      credit_q     <= {NumRs{CW'(RS_DEPTH)}};
      alu_ptr_q    <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      alu_ptr_q    <= alu_ptr_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign CreditErr = credit_err_q;

endmodule
